// File: rtl/bus_pkg.sv
// Shared types and constants for the internal 8-bit bus and its keeper stage.
package bus_pkg;

  typedef logic [7:0] bus_byte_t;

  typedef enum logic [1:0] {
    DRIVEN     = 2'd0,
    PRECHARGED = 2'd1,
    HELD       = 2'd2,
    DECAYED    = 2'd3
  } keeper_state_t;

  localparam bus_byte_t   BUS_PRECHARGE_VALUE = 8'hFF;
  localparam int unsigned STAT_W              = 16;

endpackage

// File: rtl/bus_keeper_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bus_keeper.sv
// Bus keeper: retains the last driven bus value, supports precharge to 8'hFF
// and decays floating charge after DECAY_CYCLES idle cycles.
// Optional statistics counters enabled by defining BUS_KEEPER_STATS_EN.
module bus_keeper
  import bus_pkg::*;
#(
  parameter int unsigned DECAY_CYCLES = 16,
  parameter bus_byte_t   DECAY_VALUE  = 8'hFF,
  parameter int unsigned AGE_W        = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        bus_value,
  input  logic              bus_driven,
  input  logic              precharge,
  output logic [7:0]        out_value,
  output logic [7:0]        held_value,
  output logic              floating,
  output logic              decayed,
  output logic [AGE_W-1:0]  float_age,
  output logic [STAT_W-1:0] float_count,
  output logic [STAT_W-1:0] decay_count
);

  localparam bit               DECAY_EN  = (DECAY_CYCLES != 0);
  localparam logic [AGE_W:0]   DECAY_TGT = (AGE_W+1)'(DECAY_CYCLES);

  keeper_state_t   state_q;
  keeper_state_t   state_d;
  bus_byte_t       held_q;
  bus_byte_t       held_d;
  logic            decayed_q;
  logic            decayed_d;
  logic            decay_hit;
  logic            age_clr;
  logic            age_inc;
  logic [AGE_W:0]  age_plus1;

  // One-wider sum so the decay compare cannot alias on wrap.
  assign age_plus1 = {1'b0, float_age} + (AGE_W+1)'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRECHARGED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: drive beats precharge beats idle aging; DECAYED is sticky while idle.
  always_comb begin
    state_d   = state_q;
    decay_hit = 1'b0;
    if (bus_driven) begin
      state_d = DRIVEN;
    end else if (precharge) begin
      state_d = PRECHARGED;
    end else if (state_q != DECAYED) begin
      state_d = HELD;
      if (DECAY_EN && (age_plus1 == DECAY_TGT)) begin
        state_d   = DECAYED;
        decay_hit = 1'b1;
      end
    end
  end

  // Outputs and datapath next values.
  always_comb begin
    out_value = bus_driven ? bus_value : held_q;
    floating  = ~bus_driven;
    held_d    = held_q;
    if (bus_driven) begin
      held_d = bus_value;
    end else if (precharge) begin
      held_d = BUS_PRECHARGE_VALUE;
    end else if (decay_hit) begin
      held_d = DECAY_VALUE;
    end
    decayed_d = (state_d == DECAYED);
    age_clr   = bus_driven | precharge | decay_hit;
    age_inc   = ~age_clr & (state_q != DECAYED);
  end

  // Charge state and decayed flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q    <= BUS_PRECHARGE_VALUE;
      decayed_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      decayed_q <= decayed_d;
    end
  end

  assign held_value = held_q;
  assign decayed    = decayed_q;

  // Float-age counter; saturates when decay is disabled.
  sat_counter #(.W(AGE_W)) u_age (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (age_clr),
    .inc_i   (age_inc),
    .count_o (float_age)
  );

`ifdef BUS_KEEPER_STATS_EN
  logic enter_held;
  logic enter_decay;

  // Transition strobes for the statistics counters.
  always_comb begin
    enter_held  = (state_q == DRIVEN) && (state_d == HELD);
    enter_decay = (state_q != DECAYED) && (state_d == DECAYED);
  end

  sat_counter #(.W(STAT_W)) u_float_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .inc_i   (enter_held),
    .count_o (float_count)
  );

  sat_counter #(.W(STAT_W)) u_decay_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .inc_i   (enter_decay),
    .count_o (decay_count)
  );
`else
  assign float_count = '0;
  assign decay_count = '0;
`endif

endmodule

// File: tb/tb_bus_keeper.sv
// Scoreboard bench for bus_keeper: three instances (DECAY_CYCLES 16, 2, 0)
// share one stimulus stream and are checked against a behavioural model.
module tb_bus_keeper;

  localparam int NI = 3;
  localparam int M_DRV = 0;
  localparam int M_PRE = 1;
  localparam int M_HELD = 2;
  localparam int M_DEC = 3;

  typedef struct {
    int         inst;
    logic [7:0] out_v;
    logic [7:0] held;
    logic       flt;
    logic       dec;
    logic [4:0] age;
    logic [15:0] fc;
    logic [15:0] dc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  bus_value = 8'h00;
  logic        bus_driven = 1'b0;
  logic        precharge = 1'b0;

  logic [7:0]  out_v [NI];
  logic [7:0]  held_v [NI];
  logic        flt_v [NI];
  logic        dec_v [NI];
  logic [4:0]  age_v [NI];
  logic [15:0] fc_v [NI];
  logic [15:0] dc_v [NI];

  int checks = 0;
  int failures = 0;

  exp_t sb[$];

  int ncyc [NI] = '{16, 2, 0};
  int m_held [NI];
  int m_age [NI];
  int m_mode [NI];
  int m_fc [NI];
  int m_dc [NI];

  always #5 clk = ~clk;

  bus_keeper #(.DECAY_CYCLES(16), .DECAY_VALUE(8'hFF), .AGE_W(5)) dut0 (
    .clk(clk), .reset(reset), .bus_value(bus_value), .bus_driven(bus_driven),
    .precharge(precharge), .out_value(out_v[0]), .held_value(held_v[0]),
    .floating(flt_v[0]), .decayed(dec_v[0]), .float_age(age_v[0]),
    .float_count(fc_v[0]), .decay_count(dc_v[0]));

  bus_keeper #(.DECAY_CYCLES(2), .DECAY_VALUE(8'hFF), .AGE_W(5)) dut1 (
    .clk(clk), .reset(reset), .bus_value(bus_value), .bus_driven(bus_driven),
    .precharge(precharge), .out_value(out_v[1]), .held_value(held_v[1]),
    .floating(flt_v[1]), .decayed(dec_v[1]), .float_age(age_v[1]),
    .float_count(fc_v[1]), .decay_count(dc_v[1]));

  bus_keeper #(.DECAY_CYCLES(0), .DECAY_VALUE(8'hFF), .AGE_W(5)) dut2 (
    .clk(clk), .reset(reset), .bus_value(bus_value), .bus_driven(bus_driven),
    .precharge(precharge), .out_value(out_v[2]), .held_value(held_v[2]),
    .floating(flt_v[2]), .decayed(dec_v[2]), .float_age(age_v[2]),
    .float_count(fc_v[2]), .decay_count(dc_v[2]));

  function automatic int sat16(input int x);
    return (x >= 65535) ? 65535 : x + 1;
  endfunction

  // Reference behaviour for one clock edge of instance i.
  task automatic model_step(input int i, input logic r, input logic d,
                            input logic [7:0] v, input logic p);
    int na;
    if (r) begin
      m_held[i] = 255; m_age[i] = 0; m_mode[i] = M_PRE; m_fc[i] = 0; m_dc[i] = 0;
    end else if (d) begin
      m_held[i] = int'(v); m_age[i] = 0; m_mode[i] = M_DRV;
    end else if (p) begin
      m_held[i] = 255; m_age[i] = 0; m_mode[i] = M_PRE;
    end else if (m_mode[i] != M_DEC) begin
      na = m_age[i] + 1;
      if (ncyc[i] != 0 && na == ncyc[i]) begin
        m_held[i] = 255; m_age[i] = 0; m_mode[i] = M_DEC; m_dc[i] = sat16(m_dc[i]);
      end else begin
        if (m_mode[i] == M_DRV) m_fc[i] = sat16(m_fc[i]);
        m_mode[i] = M_HELD;
        m_age[i] = (na > 31) ? 31 : na;
      end
    end
  endtask

  // One clock of stimulus; pushes this cycle's expected view, then advances the model.
  task automatic cyc(input logic r, input logic d, input logic [7:0] v,
                     input logic p, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; bus_driven = d; bus_value = v; precharge = p;
    for (int i = 0; i < NI; i++) begin
      if (chk) begin
        e.inst  = i;
        e.out_v = d ? v : 8'(m_held[i]);
        e.held  = 8'(m_held[i]);
        e.flt   = ~d;
        e.dec   = (m_mode[i] == M_DEC);
        e.age   = 5'(m_age[i]);
`ifdef BUS_KEEPER_STATS_EN
        e.fc    = 16'(m_fc[i]);
        e.dc    = 16'(m_dc[i]);
`else
        e.fc    = 16'h0000;
        e.dc    = 16'h0000;
`endif
        sb.push_back(e);
      end
      model_step(i, r, d, v, p);
    end
  endtask

  task automatic cmp(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", name, inst, $time, act, req);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // Monitor: compare every pending expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("out_value",   e.inst, 32'(out_v[e.inst]),  32'(e.out_v));
        cmp("held_value",  e.inst, 32'(held_v[e.inst]), 32'(e.held));
        cmp("floating",    e.inst, 32'(flt_v[e.inst]),  32'(e.flt));
        cmp("decayed",     e.inst, 32'(dec_v[e.inst]),  32'(e.dec));
        cmp("float_age",   e.inst, 32'(age_v[e.inst]),  32'(e.age));
        cmp("float_count", e.inst, 32'(fc_v[e.inst]),   32'(e.fc));
        cmp("decay_count", e.inst, 32'(dc_v[e.inst]),   32'(e.dc));
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    for (int i = 0; i < NI; i++) begin
      m_held[i] = 0; m_age[i] = 0; m_mode[i] = M_PRE; m_fc[i] = 0; m_dc[i] = 0;
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    // Reset then idle: precharge value held, age counts up.
    idle(4);
    // Drive 5A then float through decay.
    cyc(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1);
    idle(19);
    // Drive and precharge together: drive wins.
    cyc(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
    idle(2);
    // Drive 00, float, precharge.
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    idle(2);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(2);
    // Reset mid-float.
    cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    idle(5);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);
    // Repeated drive / float bursts for the statistics counters.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 8'(k * 17 + 1), 1'b0, 1'b1);
      idle(3);
    end
    // Long float: decay-disabled instance saturates its age.
    idle(40);
    // Precharge out of DECAYED.
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(1);
    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic r, d, p;
      logic [7:0] v;
      r = ($urandom_range(0, 59) == 0);
      d = ($urandom_range(0, 9) < 3);
      p = ($urandom_range(0, 9) < 1);
      v = 8'($urandom);
      cyc(r, d, v, p, 1'b1);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_keeper.md
Name: bus_keeper

Overview:
- Sequential stage directly downstream of the internal 8-bit bus resolver.
- Consumes the resolved bus value and driven flag each cycle.
- Models NMOS bus charge retention: holds the last driven value while no driver is enabled, supports explicit precharge to 8'hFF, and decays the held charge to a fixed value after a programmable float time.
- Feeds register latches and ALU inputs with a defined value every cycle, including when the bus floats.

Parameters:
- DECAY_CYCLES, 16, consecutive undriven, non-precharged cycles before held charge decays; 0 disables decay.
- DECAY_VALUE, 8'hFF, value the bus reads once decayed.
- AGE_W, 5, width of float-age counter; must satisfy 2**AGE_W > DECAY_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- bus_value  input  8  resolved bus value, pull-downs already applied
- bus_driven  input  1  at least one driver enabled this cycle
- precharge  input  1  precharge strobe; charges the bus to 8'hFF
- out_value  output  8  value seen by bus consumers this cycle
- held_value  output  8  registered charge state
- floating  output  1  bus not driven this cycle (combinational, equals ~bus_driven)
- decayed  output  1  registered; state is DECAYED
- float_age  output  AGE_W  registered count of consecutive undriven, non-precharged cycles
- float_count  output  16  stats counter (see Optional Feature)
- decay_count  output  16  stats counter (see Optional Feature)

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- States: DRIVEN, PRECHARGED, HELD, DECAYED.
- Reset values: state PRECHARGED, held_value 8'hFF, float_age 0, decayed 0, float_count 0, decay_count 0.
- out_value is combinational: bus_driven ? bus_value : held_value.
  - A driven value is visible in the same cycle (zero latency).
  - A retained value is visible from the next cycle onward.
- Per-clock priority, highest first:
  - reset.
  - bus_driven=1: held_value<=bus_value; state<=DRIVEN; float_age<=0. Wins over a simultaneous precharge.
  - precharge=1: held_value<=8'hFF; state<=PRECHARGED; float_age<=0.
  - Otherwise, in DRIVEN/PRECHARGED/HELD:
    - state<=HELD; float_age<=float_age+1.
    - If DECAY_CYCLES!=0 and float_age+1==DECAY_CYCLES: state<=DECAYED, held_value<=DECAY_VALUE, float_age<=0.
  - Otherwise, in DECAYED: hold everything; float_age stays 0.
- Decay timing: with DECAY_CYCLES=N, the Nth consecutive idle cycle's clock edge applies DECAY_VALUE. out_value shows it from cycle N+1.
- DECAY_CYCLES=1: decays on the first idle edge and never enters HELD with a retained value.
- float_age saturates at 2**AGE_W-1 when decay is disabled; no wrap.
- A precharge in DECAYED returns to PRECHARGED. A driven cycle returns from any state to DRIVEN.
- Reset mid-float discards the held value and float_age immediately at that edge.
- Glitch-free outputs: held_value, decayed and float_age change only on clock edges.

Optional Feature:
- Macro: BUS_KEEPER_STATS_EN.
- With macro defined:
  - float_count increments once per DRIVEN->HELD transition.
  - decay_count increments once per entry into DECAYED.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Without macro: both ports are tied to 16'h0000 and no counter logic is synthesised. All other behaviour is identical.

Decomposition:
- Shared package bus_pkg holds:
  - typedef bus_byte_t (logic [7:0]).
  - enum keeper_state_t {DRIVEN, PRECHARGED, HELD, DECAYED}.
  - constant BUS_PRECHARGE_VALUE = 8'hFF.
  - constant STAT_W = 16.
- One natural sub-module: sat_counter (width parameter; clear, increment, saturating output). Used for float_age and both stats counters.

Test Plan:
- Reset then idle 3 cycles (DECAY_CYCLES=16) -> out_value=8'hFF, state HELD, float_age=3, decayed=0.
- Drive 8'h5A for 1 cycle, then idle 15 cycles -> out_value=8'h5A throughout; float_age=15; 16th idle edge -> held_value=DECAY_VALUE, decayed=1, float_age=0.
- bus_driven=1 and precharge=1 together with bus_value=8'h3C -> out_value=8'h3C same cycle; held_value=8'h3C next cycle, state DRIVEN.
- Drive 8'h00, idle 2 cycles, precharge 1 cycle -> out_value 8'h00, 8'h00, then 8'hFF from the cycle after the precharge edge; float_age=0.
- Drive 8'hA5, idle 5 cycles, assert reset for 1 cycle -> held_value=8'hFF, float_age=0, decayed=0, state PRECHARGED.
- With BUS_KEEPER_STATS_EN, DECAY_CYCLES=2: repeat 4 times (drive 1, idle 3) -> float_count=4, decay_count=4. Without the macro, both read 16'h0000.
